status_array_ctrl: RTL and testbench
====================================

// Module: status_array_ctrl
// PURPOSE
//   Sequencer and arbiter in front of status_array. After reset or a flush it sweeps every status
//   row to zero; afterwards it grants the single status_array access slot each cycle to either the
//   lookup path (read) or the fill/replacement update path (masked write).
//   Reads and writes are mutually exclusive because status_array zeroes o_data in a cycle that
//   follows a write.
// PARAMETERS
//   TAG_WIDTH      1   width of the lookup tag carried alongside a read
//   UP_BURST_MAX   4   max consecutive update grants while a lookup waits; >=1
//   ADDR_WIDTH, ROW_WIDTH, NUM_BLOCKS: from shared_params.vh; NUM_ROWS = 2**ADDR_WIDTH
// PORTS
//   clk            in   1             clock, single domain
//   arst_n         in   1             asynchronous active-low reset
//   i_halt         in   1             pipeline halt; same signal that gates status_array clock
//   i_flush        in   1             one-cycle pulse: re-zero all rows
//   i_lk_valid     in   1             lookup request
//   i_lk_addr      in   ADDR_WIDTH    lookup row
//   i_lk_tag       in   TAG_WIDTH     tag to propagate with lookup
//   o_lk_ready     out  1             lookup accepted this cycle (valid & ready = issue)
//   i_up_valid     in   1             update request
//   i_up_addr      in   ADDR_WIDTH    update row
//   i_up_data      in   ROW_WIDTH     update data
//   i_up_wmask     in   NUM_BLOCKS    per-block write mask
//   o_up_ready     out  1             update accepted this cycle
//   o_sa_r_valid / o_sa_r_addr / o_sa_tag            out  1/ADDR_WIDTH/TAG_WIDTH   to status_array read port
//   o_sa_w_valid / o_sa_w_addr / o_sa_w_data / o_sa_w_wmask  out  1/ADDR_WIDTH/ROW_WIDTH/NUM_BLOCKS  to write port
//   o_init_done    out  1             1 when in RUN (status contents valid)
// BEHAVIOUR
//   - States: RST -> INIT -> RUN; RUN -> INIT on accepted flush. Registers update only when i_halt=0.
//   - Reset: state=RST, row counter=0, burst counter=0, flush_pend=0. All o_sa_*_valid, o_lk_ready,
//     o_up_ready, o_init_done = 0 while in RST (no write is driven during or at exit of reset).
//   - RST: first non-halted clk edge -> INIT.
//   - INIT: o_sa_w_valid=1, w_addr=row counter, w_data=0, wmask=all ones; o_lk_ready=o_up_ready=0.
//     Counter +1 per non-halted cycle. When counter==NUM_ROWS-1 the write is issued, the counter
//     wraps to 0 and the state goes to RUN. Sweep takes exactly NUM_ROWS non-halted cycles.
//   - RUN arbitration (combinational, at most one of o_sa_r_valid/o_sa_w_valid high):
//     * update only -> write; lookup only -> read.
//     * both -> update wins unless burst counter==UP_BURST_MAX, in which case lookup wins.
//     * Burst counter: +1 on each update grant while i_lk_valid=1, cleared on any lookup grant or
//       cycle with i_lk_valid=0, saturates at UP_BURST_MAX.
//     * Ready = grant: o_up_ready / o_lk_ready high only for the granted requester.
//   - Outputs to status_array are a combinational mux of the granted request, i.e. zero added
//     latency; read data appears at status_array output 1 cycle after grant. Non-granted o_sa_*
//     address/data fields = 0.
//   - Flush: i_flush sets flush_pend (any state except RST). In RUN with flush_pend=1, no grants
//     issue; next edge -> INIT, clear flush_pend. A grant issued in the same cycle as the i_flush
//     pulse completes normally. A flush during INIT is absorbed: flush_pend clears, the sweep continues.
//   - i_halt=1: all readies and o_sa_*_valid forced 0; state and counters hold; i_flush is still
//     captured into flush_pend.
//   - Async reset mid-sweep or mid-burst: everything returns to RST values immediately; a fresh
//     full sweep follows.
// STRUCTURE
//   - shared_params.vh supplies ADDR_WIDTH/ROW_WIDTH/NUM_BLOCKS; add NUM_ROWS and state encodings
//     (SAC_RST=2'd0, SAC_INIT=2'd1, SAC_RUN=2'd2) there.
//   - Single module. The fairness logic fits as one sub-module, sac_fair_arb (2-way priority +
//     burst counter). Instantiate alongside status_array in the cache top.
// TESTING
//   - Reset release, no requests -> w_valid high 16 cycles, addr 0..15, data 0, wmask all ones;
//     o_init_done=1 on cycle 17; no r_valid during sweep.
//   - In RUN: lookup addr 3 tag 1 alone -> o_lk_ready=1 same cycle, o_sa_r_addr=3, o_sa_tag=1,
//     w_valid=0.
//   - Continuous update + lookup both valid, UP_BURST_MAX=4 -> grant pattern U,U,U,U,L repeating;
//     r_valid and w_valid never high together.
//   - Halt for 5 cycles at sweep row 7 -> no valids during halt; resumes at row 7; done 5 cycles late.
//   - i_flush in RUN with pending lookup -> no grants next cycle, full 16-row sweep, then lookup served.
//   - arst_n pulsed at sweep row 10 -> outputs to reset values asynchronously; new sweep starts at row 0.

Source files
------------

// File: rtl/status_array_ctrl_pkg.sv
// Shared sizing and state encoding for the status_array sequencer/arbiter.
package status_array_ctrl_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int ROW_WIDTH  = 8;
  localparam int NUM_BLOCKS = 4;
  localparam int NUM_ROWS   = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    SAC_RST  = 2'd0,
    SAC_INIT = 2'd1,
    SAC_RUN  = 2'd2
  } sac_state_e;

endpackage

// File: rtl/status_array_ctrl_fair_arb.sv
// Two-way priority arbiter (the sac_fair_arb function) for the status_array access slot.
// Updates win by default. A burst counter bounds how many update grants in a row a
// waiting lookup can be starved for; at the limit the lookup takes the slot.
module status_array_ctrl_fair_arb #(
  parameter int UP_BURST_MAX = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic lk_valid,
  input  logic up_valid,
  output logic lk_grant,
  output logic up_grant
);

  localparam int CW = $clog2(UP_BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(UP_BURST_MAX);

  logic [CW-1:0] burst_cnt;
  logic          burst_full;

  assign burst_full = (burst_cnt == BURST_LIMIT);

  // Grant decision: at most one requester wins, and only while arbitration is enabled.
  always_comb begin
    lk_grant = en & lk_valid & (~up_valid | burst_full);
    up_grant = en & up_valid & ~(lk_valid & burst_full);
  end

  // Burst counter counts update grants taken while a lookup waits; it only moves on arbitration cycles.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      burst_cnt <= '0;
    end else if (en) begin
      if (!lk_valid || lk_grant) begin
        burst_cnt <= '0;
      end else if (up_grant && !burst_full) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_array_ctrl.sv
// Sequencer and arbiter in front of status_array.
// After reset or a flush every row is swept to zero, then the single access slot is
// granted each cycle to either a lookup (read) or an update (masked write), never both.
// Handshake: a request is issued in the cycle where its valid and ready are both high;
// ready is the grant itself, so it may depend combinationally on valid.
module status_array_ctrl
  import status_array_ctrl_pkg::*;
#(
  parameter int TAG_WIDTH    = 1,
  parameter int UP_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_flush,
  input  logic                  i_lk_valid,
  input  logic [ADDR_WIDTH-1:0] i_lk_addr,
  input  logic [TAG_WIDTH-1:0]  i_lk_tag,
  output logic                  o_lk_ready,
  input  logic                  i_up_valid,
  input  logic [ADDR_WIDTH-1:0] i_up_addr,
  input  logic [ROW_WIDTH-1:0]  i_up_data,
  input  logic [NUM_BLOCKS-1:0] i_up_wmask,
  output logic                  o_up_ready,
  output logic                  o_sa_r_valid,
  output logic [ADDR_WIDTH-1:0] o_sa_r_addr,
  output logic [TAG_WIDTH-1:0]  o_sa_tag,
  output logic                  o_sa_w_valid,
  output logic [ADDR_WIDTH-1:0] o_sa_w_addr,
  output logic [ROW_WIDTH-1:0]  o_sa_w_data,
  output logic [NUM_BLOCKS-1:0] o_sa_w_wmask,
  output logic                  o_init_done,
  output logic [1:0]            o_dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

  sac_state_e            state;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic                  flush_pend;
  logic                  arb_en;
  logic                  lk_grant;
  logic                  up_grant;
  logic                  sweep_wr;

  // A pending flush blocks new grants so the slot is quiet before the re-sweep.
  assign arb_en   = (state == SAC_RUN) & ~i_halt & ~flush_pend;
  assign sweep_wr = (state == SAC_INIT) & ~i_halt;

  status_array_ctrl_fair_arb #(
    .UP_BURST_MAX (UP_BURST_MAX)
  ) u_fair_arb (
    .clk      (clk),
    .arst_n   (arst_n),
    .en       (arb_en),
    .lk_valid (i_lk_valid),
    .up_valid (i_up_valid),
    .lk_grant (lk_grant),
    .up_grant (up_grant)
  );

  // Sequencer: RST -> INIT sweep -> RUN; a flush seen in RUN sends it back to INIT.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= SAC_RST;
      row_cnt    <= '0;
      flush_pend <= 1'b0;
    end else if (i_halt) begin
      // Everything holds except that a flush pulse must not be lost.
      if (state != SAC_RST) begin
        flush_pend <= flush_pend | i_flush;
      end
    end else begin
      case (state)
        SAC_RST: begin
          state <= SAC_INIT;
        end
        SAC_INIT: begin
          // The sweep already zeroes everything, so a flush here is simply absorbed.
          flush_pend <= 1'b0;
          if (row_cnt == LAST_ROW) begin
            row_cnt <= '0;
            state   <= SAC_RUN;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        SAC_RUN: begin
          if (flush_pend) begin
            flush_pend <= 1'b0;
            state      <= SAC_INIT;
          end else begin
            flush_pend <= i_flush;
          end
        end
        default: begin
          state <= SAC_RST;
        end
      endcase
    end
  end

  // Port mux: sweep write, granted update or granted lookup; idle fields are driven to zero.
  always_comb begin
    o_lk_ready   = lk_grant;
    o_up_ready   = up_grant;
    o_sa_r_valid = lk_grant;
    o_sa_r_addr  = lk_grant ? i_lk_addr : '0;
    o_sa_tag     = lk_grant ? i_lk_tag : '0;
    o_sa_w_valid = sweep_wr | up_grant;
    o_sa_w_addr  = '0;
    o_sa_w_data  = '0;
    o_sa_w_wmask = '0;
    if (sweep_wr) begin
      o_sa_w_addr  = row_cnt;
      o_sa_w_wmask = '1;
    end else if (up_grant) begin
      o_sa_w_addr  = i_up_addr;
      o_sa_w_data  = i_up_data;
      o_sa_w_wmask = i_up_wmask;
    end
    o_init_done  = (state == SAC_RUN);
    o_dbg_state  = state;
  end

endmodule

// File: tb/tb_status_array_ctrl.sv
// Self-checking bench for status_array_ctrl with a cycle-level behavioural model.
module tb_status_array_ctrl;

  localparam int AW    = 4;
  localparam int RW    = 8;
  localparam int NB    = 4;
  localparam int ROWS  = 16;
  localparam int BURST = 4;
  localparam int OUTW  = 28;

  logic          clk;
  logic          arst_n;
  logic          halt, flush;
  logic          lkv, upv;
  logic [AW-1:0] lka, upa;
  logic [0:0]    lkt;
  logic [RW-1:0] upd;
  logic [NB-1:0] upm;
  logic          lk_ready, up_ready;
  logic          sa_r_valid, sa_w_valid;
  logic [AW-1:0] sa_r_addr, sa_w_addr;
  logic [0:0]    sa_tag;
  logic [RW-1:0] sa_w_data;
  logic [NB-1:0] sa_w_wmask;
  logic          init_done;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_q[$];

  // model: phase 0=reset 1=sweep 2=run
  int m_phase, m_row, m_streak;
  bit m_flush;

  status_array_ctrl #(.TAG_WIDTH(1), .UP_BURST_MAX(BURST)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_halt       (halt),
    .i_flush      (flush),
    .i_lk_valid   (lkv),
    .i_lk_addr    (lka),
    .i_lk_tag     (lkt),
    .o_lk_ready   (lk_ready),
    .i_up_valid   (upv),
    .i_up_addr    (upa),
    .i_up_data    (upd),
    .i_up_wmask   (upm),
    .o_up_ready   (up_ready),
    .o_sa_r_valid (sa_r_valid),
    .o_sa_r_addr  (sa_r_addr),
    .o_sa_tag     (sa_tag),
    .o_sa_w_valid (sa_w_valid),
    .o_sa_w_addr  (sa_w_addr),
    .o_sa_w_data  (sa_w_data),
    .o_sa_w_wmask (sa_w_wmask),
    .o_init_done  (init_done),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUTW-1:0] dut_vec();
    return {dbg_state, init_done, lk_ready, up_ready, sa_r_valid, sa_r_addr, sa_tag,
            sa_w_valid, sa_w_addr, sa_w_data, sa_w_wmask};
  endfunction

  // 0 none, 1 lookup, 2 update
  function automatic int model_grant();
    if (halt || m_phase != 2 || m_flush) return 0;
    if (upv && lkv) return (m_streak >= BURST) ? 1 : 2;
    if (upv) return 2;
    if (lkv) return 1;
    return 0;
  endfunction

  function automatic logic [OUTW-1:0] model_out();
    logic [1:0] st; logic done, lr, ur, rv, wv;
    logic [AW-1:0] ra, wa; logic [0:0] tg; logic [RW-1:0] wd; logic [NB-1:0] wm;
    int g;
    g = model_grant();
    st = 2'(m_phase); done = (m_phase == 2);
    lr = 0; ur = 0; rv = 0; wv = 0; ra = '0; wa = '0; tg = '0; wd = '0; wm = '0;
    if (!halt && m_phase == 1) begin
      wv = 1; wa = AW'(m_row); wm = '1;
    end
    if (g == 1) begin
      lr = 1; rv = 1; ra = lka; tg = lkt;
    end else if (g == 2) begin
      ur = 1; wv = 1; wa = upa; wd = upd; wm = upm;
    end
    return {st, done, lr, ur, rv, ra, tg, wv, wa, wd, wm};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_row = 0; m_streak = 0; m_flush = 0;
  endtask

  task automatic model_step();
    int g; bit en;
    g  = model_grant();
    en = !halt && m_phase == 2 && !m_flush;
    if (halt) begin
      if (m_phase != 0) m_flush = m_flush | flush;
      return;
    end
    if (en) begin
      if (!lkv || g == 1) m_streak = 0;
      else if (g == 2 && m_streak < BURST) m_streak++;
    end
    case (m_phase)
      0: begin m_phase = 1; m_row = 0; end
      1: begin
        m_flush = 0;
        if (m_row == ROWS - 1) begin m_phase = 2; m_row = 0; end
        else m_row++;
      end
      default: begin
        if (m_flush) begin m_phase = 1; m_flush = 0; end
        else m_flush = flush;
      end
    endcase
  endtask

  // driver tasks
  task automatic set_idle();
    halt = 0; flush = 0; lkv = 0; upv = 0;
    lka = '0; upa = '0; lkt = '0; upd = '0; upm = '0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    if (arst_n) model_step();
  endtask

  task automatic test_reset();
    set_idle();
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (dut_vec() !== model_out()) begin
        bad++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), model_out());
      end
      total++;
      if (init_done !== 1'b0 || sa_w_valid !== 1'b0) begin
        bad++; $display("FAIL reset_idle: got done=%b w_valid=%b expected 0/0", init_done, sa_w_valid);
      end
      next_edge();
    end
  endtask

  task automatic test_sweep();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(AW'(r));
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 0) arst_n = 1'b1;
      #1;
      total++;
      if (dut_vec() !== model_out()) begin
        bad++; $display("FAIL sweep_cycle%0d: got %h expected %h", c, dut_vec(), model_out());
      end
      if (sa_w_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL sweep_extra_write: got addr %0d expected none", sa_w_addr);
        end else if (sa_w_addr !== exp_q[0] || sa_w_data !== '0 || sa_w_wmask !== 4'hF) begin
          bad++; $display("FAIL sweep_write: got %0d/%h/%h expected %0d/00/f",
                          sa_w_addr, sa_w_data, sa_w_wmask, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (sa_r_valid === 1'b1) begin
        total++; bad++; $display("FAIL sweep_read: got r_valid 1 expected 0");
      end
      if (c == 17) begin
        total++;
        if (init_done !== 1'b1 || exp_q.size() != 0) begin
          bad++; $display("FAIL sweep_done: got done=%b left=%0d expected 1/0", init_done, exp_q.size());
        end
      end
      next_edge();
    end
  endtask

  task automatic test_lookup_alone();
    @(negedge clk);
    set_idle(); lkv = 1; lka = 4'd3; lkt = 1'b1;
    #1;
    total++;
    if (dut_vec() !== model_out()) begin
      bad++; $display("FAIL lookup_vec: got %h expected %h", dut_vec(), model_out());
    end
    total++;
    if (lk_ready !== 1'b1 || sa_r_addr !== 4'd3 || sa_tag !== 1'b1 || sa_w_valid !== 1'b0) begin
      bad++; $display("FAIL lookup_alone: got rdy=%b addr=%0d tag=%b wv=%b expected 1/3/1/0",
                      lk_ready, sa_r_addr, sa_tag, sa_w_valid);
    end
    next_edge();
    @(negedge clk); set_idle(); #1;
    next_edge();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      lkv = 1; upv = 1;
      lka = AW'($urandom_range(0, ROWS - 1)); lkt = 1'($urandom_range(0, 1));
      upa = AW'($urandom_range(0, ROWS - 1)); upd = RW'($urandom_range(0, 255));
      upm = NB'($urandom_range(0, 15));
      #1;
      total++;
      if (dut_vec() !== model_out()) begin
        bad++; $display("FAIL burst_vec%0d: got %h expected %h", k, dut_vec(), model_out());
      end
      total++;
      if (lk_ready !== ((k % 5) == 4) || up_ready !== ((k % 5) != 4) || (sa_r_valid & sa_w_valid)) begin
        bad++; $display("FAIL burst_pattern%0d: got lk=%b up=%b expected lk=%b", k, lk_ready, up_ready, (k % 5) == 4);
      end
      next_edge();
    end
    @(negedge clk); set_idle(); #1;
    next_edge();
  endtask

  task automatic test_flush();
    int writes;
    writes = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      set_idle(); lkv = 1; lka = 4'd5;
      if (c == 0) flush = 1;
      #1;
      total++;
      if (dut_vec() !== model_out()) begin
        bad++; $display("FAIL flush_vec%0d: got %h expected %h", c, dut_vec(), model_out());
      end
      if (sa_w_valid === 1'b1) writes++;
      if (c == 0 || c == 1 || c == 18) begin
        total++;
        if (lk_ready !== (c != 1) || (c == 1 && sa_w_valid !== 1'b0)) begin
          bad++; $display("FAIL flush_grant%0d: got lk=%b wv=%b expected lk=%b", c, lk_ready, sa_w_valid, c != 1);
        end
      end
      next_edge();
    end
    total++;
    if (writes != ROWS) begin
      bad++; $display("FAIL flush_sweep_len: got %0d expected %0d", writes, ROWS);
    end
    @(negedge clk); set_idle(); #1;
    next_edge();
  endtask

  task automatic test_arst_mid_sweep();
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      set_idle();
      if (k == 0) flush = 1;
      #1;
      total++;
      if (dut_vec() !== model_out()) begin
        bad++; $display("FAIL arst_pre%0d: got %h expected %h", k, dut_vec(), model_out());
      end
      if (k == 12) begin
        total++;
        if (sa_w_addr !== 4'd10) begin
          bad++; $display("FAIL arst_row: got %0d expected 10", sa_w_addr);
        end
        #2 arst_n = 1'b0;
        #1 model_reset();
        total++;
        if (dut_vec() !== model_out() || sa_w_valid !== 1'b0) begin
          bad++; $display("FAIL arst_async: got %h expected %h", dut_vec(), model_out());
        end
      end
      next_edge();
    end
  endtask

  task automatic test_halt_sweep();
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      set_idle();
      if (c == 0) arst_n = 1'b1;
      halt = (c >= 8 && c < 13);
      if (c == 10) flush = 1;
      #1;
      total++;
      if (dut_vec() !== model_out()) begin
        bad++; $display("FAIL halt_vec%0d: got %h expected %h", c, dut_vec(), model_out());
      end
      if (halt && (sa_w_valid !== 1'b0 || sa_r_valid !== 1'b0)) begin
        total++; bad++; $display("FAIL halt_quiet%0d: got wv=%b rv=%b expected 0/0", c, sa_w_valid, sa_r_valid);
      end
      if (c == 1 || c == 13) begin
        total++;
        if (sa_w_addr !== ((c == 1) ? 4'd0 : 4'd7)) begin
          bad++; $display("FAIL halt_resume%0d: got %0d expected %0d", c, sa_w_addr, (c == 1) ? 0 : 7);
        end
      end
      if (c >= 21) begin
        total++;
        if (init_done !== (c == 22)) begin
          bad++; $display("FAIL halt_done%0d: got %b expected %b", c, init_done, c == 22);
        end
      end
      next_edge();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      halt  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 39) == 0);
      lkv   = 1'($urandom_range(0, 1));
      upv   = 1'($urandom_range(0, 1));
      lka   = AW'($urandom_range(0, ROWS - 1)); lkt = 1'($urandom_range(0, 1));
      upa   = AW'($urandom_range(0, ROWS - 1)); upd = RW'($urandom_range(0, 255));
      upm   = NB'($urandom_range(0, 15));
      #1;
      total++;
      if (dut_vec() !== model_out()) begin
        bad++; $display("FAIL random%0d: got %h expected %h", n, dut_vec(), model_out());
      end
      next_edge();
    end
    @(negedge clk); set_idle();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_lookup_alone();
    test_back_to_back();
    test_flush();
    test_arst_mid_sweep();
    test_halt_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
